// File: rtl/riscv_csr_pkg.sv
// Shared supervisor CSR definitions: CSR addresses, sstatus bit positions
// and the trap sequencing FSM state encoding.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;

    localparam int unsigned SIE_BIT  = 1;
    localparam int unsigned SPIE_BIT = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_IN_TRAP  = 3'd3,
        ST_RETURN   = 3'd4
    } trap_state_e;

endpackage

// File: rtl/supervisor_csr_file.sv
// Supervisor trap CSR storage (sstatus SIE/SPIE, stvec, sepc, scause).
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   capture           trap accepted this cycle: latch sepc_in/scause_in, stack SIE
//   sret_commit       sret accepted this cycle: restore SIE from SPIE
//   sepc_in/scause_in trap payload from the exception detection unit
//   csr_we/addr/wdata software CSR write port
//   csr_rdata         combinational read of csr_addr (pre-edge values)
//   stvec, sepc       current register values for redirect generation
module supervisor_csr_file
    import riscv_csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     CAUSE_W     = 32,
    parameter logic [XLEN-1:0] STVEC_RESET = 64'h0000_0000_0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               capture,
    input  logic               sret_commit,
    input  logic [XLEN-1:0]    sepc_in,
    input  logic [CAUSE_W-1:0] scause_in,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic [XLEN-1:0]    stvec,
    output logic [XLEN-1:0]    sepc
);

    localparam logic [XLEN-1:0] SEPC_MASK  = ~XLEN'(1);
    localparam logic [XLEN-1:0] STVEC_MASK = ~XLEN'(3);

    logic [XLEN-1:0]    stvec_q,  stvec_d;
    logic [XLEN-1:0]    sepc_q,   sepc_d;
    logic [CAUSE_W-1:0] scause_q, scause_d;
    logic               sie_q,    sie_d;
    logic               spie_q,   spie_d;

    logic wr_sstatus, wr_stvec, wr_sepc, wr_scause;

    // Software write decode
    always_comb begin
        wr_sstatus = csr_we && (csr_addr == CSR_SSTATUS);
        wr_stvec   = csr_we && (csr_addr == CSR_STVEC);
        wr_sepc    = csr_we && (csr_addr == CSR_SEPC);
        wr_scause  = csr_we && (csr_addr == CSR_SCAUSE);
    end

    // Next-state: hardware trap/sret updates take priority over software
    // writes to the fields they touch; stvec is never touched by hardware.
    always_comb begin
        stvec_d  = stvec_q;
        sepc_d   = sepc_q;
        scause_d = scause_q;
        sie_d    = sie_q;
        spie_d   = spie_q;

        if (wr_stvec) begin
            stvec_d = csr_wdata & STVEC_MASK;
        end

        if (capture) begin
            sepc_d   = sepc_in & SEPC_MASK;
            scause_d = scause_in;
            spie_d   = sie_q;
            sie_d    = 1'b0;
        end else if (sret_commit) begin
            sie_d  = spie_q;
            spie_d = 1'b1;
            if (wr_sepc) begin
                sepc_d = csr_wdata & SEPC_MASK;
            end
            if (wr_scause) begin
                scause_d = csr_wdata[CAUSE_W-1:0];
            end
        end else begin
            if (wr_sepc) begin
                sepc_d = csr_wdata & SEPC_MASK;
            end
            if (wr_scause) begin
                scause_d = csr_wdata[CAUSE_W-1:0];
            end
            if (wr_sstatus) begin
                sie_d  = csr_wdata[SIE_BIT];
                spie_d = csr_wdata[SPIE_BIT];
            end
        end
    end

    // CSR state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stvec_q  <= STVEC_RESET & STVEC_MASK;
            sepc_q   <= '0;
            scause_q <= '0;
            sie_q    <= 1'b0;
            spie_q   <= 1'b0;
        end else begin
            stvec_q  <= stvec_d;
            sepc_q   <= sepc_d;
            scause_q <= scause_d;
            sie_q    <= sie_d;
            spie_q   <= spie_d;
        end
    end

    // Read mux; unmapped addresses read zero
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_SSTATUS: begin
                csr_rdata[SIE_BIT]  = sie_q;
                csr_rdata[SPIE_BIT] = spie_q;
            end
            CSR_STVEC:  csr_rdata = stvec_q;
            CSR_SEPC:   csr_rdata = sepc_q;
            CSR_SCAUSE: csr_rdata = XLEN'(scause_q);
            default:    csr_rdata = '0;
        endcase
    end

    assign stvec = stvec_q;
    assign sepc  = sepc_q;

endmodule

// File: rtl/trap_controller.sv
// Supervisor trap sequencer: flush -> redirect to stvec -> handler -> sret
// return redirect to sepc. Owns the supervisor trap CSRs via supervisor_csr_file.
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   exception_flag/scause_in/sepc_in  trap request and payload
//   sret                        sret retiring this cycle
//   csr_we/csr_addr/csr_wdata   CSR write port; csr_rdata combinational read
//   flush, stall, pc_redirect, redirect_pc  pipeline control, decoded from state
//   trap_active                 handler executing
module trap_controller
    import riscv_csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     CAUSE_W     = 32,
    parameter logic [XLEN-1:0] STVEC_RESET = 64'h0000_0000_0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exception_flag,
    input  logic [CAUSE_W-1:0] scause_in,
    input  logic [XLEN-1:0]    sepc_in,
    input  logic               sret,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               flush,
    output logic               stall,
    output logic               pc_redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               trap_active
);

    trap_state_e state_q, state_d;

    logic            capture;
    logic            sret_commit;
    logic [XLEN-1:0] stvec;
    logic [XLEN-1:0] sepc;

    // Exceptions are only accepted where an instruction can actually retire;
    // in FLUSH/REDIRECT/RETURN the reporting instruction is being squashed.
    always_comb begin
        capture     = exception_flag &&
                      ((state_q == ST_IDLE) || (state_q == ST_IN_TRAP));
        sret_commit = (state_q == ST_IN_TRAP) && sret && !exception_flag;
    end

    supervisor_csr_file #(
        .XLEN        (XLEN),
        .CAUSE_W     (CAUSE_W),
        .STVEC_RESET (STVEC_RESET)
    ) u_csr (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .sret_commit (sret_commit),
        .sepc_in     (sepc_in),
        .scause_in   (scause_in),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .stvec       (stvec),
        .sepc        (sepc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; redirect_pc samples stvec/sepc live so
    // a stvec write landing just before REDIRECT is honoured.
    always_comb begin
        state_d     = state_q;
        flush       = 1'b0;
        stall       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        trap_active = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                stall   = 1'b1;
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_redirect = 1'b1;
                redirect_pc = stvec & ~XLEN'(3);
                state_d     = ST_IN_TRAP;
            end
            ST_IN_TRAP: begin
                trap_active = 1'b1;
                if (capture) begin
                    state_d = ST_FLUSH;
                end else if (sret_commit) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = sepc;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: CSR vector table plus directed
// trap/return/nested/reset sequences.
module tb_trap_controller;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned CAUSE_W = 32;

    logic               clk;
    logic               reset;
    logic               exception_flag;
    logic [CAUSE_W-1:0] scause_in;
    logic [XLEN-1:0]    sepc_in;
    logic               sret;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [XLEN-1:0]    csr_rdata;
    logic               flush;
    logic               stall;
    logic               pc_redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               trap_active;

    int checks;
    int failures;

    trap_controller #(
        .XLEN        (XLEN),
        .CAUSE_W     (CAUSE_W),
        .STVEC_RESET (64'h0000_0000_0000_0100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .exception_flag (exception_flag),
        .scause_in      (scause_in),
        .sepc_in        (sepc_in),
        .sret           (sret),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .flush          (flush),
        .stall          (stall),
        .pc_redirect    (pc_redirect),
        .redirect_pc    (redirect_pc),
        .trap_active    (trap_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
    } csr_vec_t;

    csr_vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags packed {flush, stall, pc_redirect, trap_active}
    task automatic check_ctl(input string name, input logic [3:0] exp);
        check(name, {60'd0, flush, stall, pc_redirect, trap_active}, {60'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_csr(input string name, input logic [11:0] addr, input logic [63:0] exp);
        csr_addr = addr;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic write_csr(input logic [11:0] addr, input logic [63:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        step();
        csr_we    = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        exception_flag = 1'b0;
        scause_in      = '0;
        sepc_in        = '0;
        sret           = 1'b0;
        csr_we         = 1'b0;
        csr_addr       = 12'h000;
        csr_wdata      = '0;

        vecs[0] = '{"stvec_mask",     12'h105, 64'h8003,                64'h8000};
        vecs[1] = '{"sstatus_mask",   12'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h22};
        vecs[2] = '{"sepc_mask",      12'h141, 64'h31,                  64'h30};
        vecs[3] = '{"scause_zext",    12'h142, 64'hFFFF_FFFF_1234_5678, 64'h1234_5678};
        vecs[4] = '{"unmapped_300",   12'h300, 64'hDEAD,                64'h0};
        vecs[5] = '{"sstatus_clear",  12'h100, 64'h0,                   64'h0};
        vecs[6] = '{"stvec_restore",  12'h105, 64'h100,                 64'h100};

        // Reset
        repeat (3) @(negedge clk);
        check_ctl("reset_ctl_asserted", 4'b0000);
        reset = 1'b1;
        step();
        check_ctl("reset_ctl", 4'b0000);
        check("reset_redirect_pc", redirect_pc, 64'h0);
        read_csr("reset_stvec", 12'h105, 64'h100);
        read_csr("reset_scause", 12'h142, 64'h0);
        read_csr("reset_sepc", 12'h141, 64'h0);
        read_csr("reset_sstatus", 12'h100, 64'h0);

        // CSR write/read table
        for (int i = 0; i < 7; i++) begin
            write_csr(vecs[i].addr, vecs[i].wdata);
            read_csr(vecs[i].name, vecs[i].addr, vecs[i].exp_rdata);
        end

        // Trap from IDLE with SIE=1 and a conflicting sepc write on the capture edge
        write_csr(12'h100, 64'h2);
        exception_flag = 1'b1;
        sepc_in        = 64'h20;
        scause_in      = 32'd2;
        csr_we         = 1'b1;
        csr_addr       = 12'h141;
        csr_wdata      = 64'h998;
        step();
        exception_flag = 1'b0;
        csr_we         = 1'b0;
        check_ctl("a_flush_cycle", 4'b1100);
        read_csr("a_sepc_capture_wins", 12'h141, 64'h20);
        read_csr("a_scause", 12'h142, 64'h2);
        read_csr("a_sstatus", 12'h100, 64'h20);
        // Exception pulse during REDIRECT must be ignored
        exception_flag = 1'b1;
        sepc_in        = 64'h400;
        scause_in      = 32'd9;
        step();
        check_ctl("a_redirect_cycle", 4'b0010);
        check("a_redirect_pc", redirect_pc, 64'h100);
        exception_flag = 1'b0;
        step();
        check_ctl("a_in_trap", 4'b0001);
        read_csr("a_sepc_kept", 12'h141, 64'h20);
        read_csr("a_scause_kept", 12'h142, 64'h2);
        step();
        check_ctl("a_in_trap_hold", 4'b0001);
        // sret
        sret = 1'b1;
        step();
        sret = 1'b0;
        check_ctl("a_return_cycle", 4'b1010);
        check("a_return_pc", redirect_pc, 64'h20);
        read_csr("a_sstatus_restored", 12'h100, 64'h22);
        // Exception pulse during RETURN must be ignored
        exception_flag = 1'b1;
        sepc_in        = 64'h500;
        step();
        exception_flag = 1'b0;
        check_ctl("a_idle_after_return", 4'b0000);
        read_csr("a_sepc_after_return", 12'h141, 64'h20);
        step();
        check_ctl("a_idle_stays", 4'b0000);

        // Misaligned capture with relocated stvec, then nested trap with sret
        write_csr(12'h105, 64'h8003);
        exception_flag = 1'b1;
        sepc_in        = 64'h31;
        scause_in      = 32'd5;
        step();
        exception_flag = 1'b0;
        check_ctl("b_flush_cycle", 4'b1100);
        read_csr("b_sepc_aligned", 12'h141, 64'h30);
        read_csr("b_sstatus", 12'h100, 64'h20);
        step();
        check("b_redirect_pc", redirect_pc, 64'h8000);
        step();
        check_ctl("b_in_trap", 4'b0001);
        exception_flag = 1'b1;
        sret           = 1'b1;
        sepc_in        = 64'h40;
        scause_in      = 32'd7;
        step();
        exception_flag = 1'b0;
        sret           = 1'b0;
        check_ctl("b_nested_flush", 4'b1100);
        read_csr("b_nested_sepc", 12'h141, 64'h40);
        read_csr("b_nested_scause", 12'h142, 64'h7);
        read_csr("b_nested_sstatus", 12'h100, 64'h0);
        step();
        check("b_nested_redirect", redirect_pc, 64'h8000);
        step();
        check_ctl("b_nested_in_trap", 4'b0001);
        sret = 1'b1;
        step();
        sret = 1'b0;
        check_ctl("b_return_cycle", 4'b1010);
        check("b_return_pc", redirect_pc, 64'h40);
        read_csr("b_sstatus_restored", 12'h100, 64'h20);
        step();
        check_ctl("b_idle", 4'b0000);

        // sret in IDLE is ignored
        sret = 1'b1;
        step();
        sret = 1'b0;
        check_ctl("c_sret_idle", 4'b0000);
        read_csr("c_sstatus_unchanged", 12'h100, 64'h20);

        // Reset asserted during FLUSH aborts the sequence
        exception_flag = 1'b1;
        sepc_in        = 64'h60;
        scause_in      = 32'd3;
        step();
        exception_flag = 1'b0;
        check_ctl("d_flush_cycle", 4'b1100);
        reset = 1'b0;
        #1;
        check_ctl("d_async_abort", 4'b0000);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ctl("d_no_redirect_after_reset", 4'b0000);
        end
        read_csr("d_sepc_reset", 12'h141, 64'h0);
        read_csr("d_stvec_reset", 12'h105, 64'h100);
        read_csr("d_unmapped_300", 12'h300, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
